// File: rtl/simple_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : simple_mem_arbiter
// Purpose  : Shares a single-ported, 1-cycle-latency memory between an
//            instruction-fetch port (I, read-only) and a load/store port
//            (D, read/write). D has priority. A starvation counter forces
//            an I grant after STARVE_LIMIT consecutive D grants while I waits.
//            Read responses are routed back to their owner one cycle later.
// Options  : SIMPLE_MEM_ARB_PERF_EN adds the perf_conflict_o and
//            perf_i_stall_o event counters.
// Revision : 1.0 - initial release
// ============================================================================
module simple_mem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  // Fetch port
  input  logic            i_req_i,
  input  logic [AW-1:0]   i_addr_i,
  output logic            i_gnt_o,
  output logic            i_rvalid_o,
  output logic [DW-1:0]   i_rdata_o,
  // Load/store port
  input  logic            d_req_i,
  input  logic            d_we_i,
  input  logic [DW/8-1:0] d_be_i,
  input  logic [AW-1:0]   d_addr_i,
  input  logic [DW-1:0]   d_wdata_i,
  output logic            d_gnt_o,
  output logic            d_rvalid_o,
  output logic [DW-1:0]   d_rdata_o,
  // Memory side
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [DW/8-1:0] mem_be_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [DW-1:0]   mem_wdata_o,
  input  logic [DW-1:0]   mem_rdata_i
`ifdef SIMPLE_MEM_ARB_PERF_EN
  ,
  output logic [31:0]     perf_conflict_o,
  output logic [31:0]     perf_i_stall_o
`endif
);

  localparam int         BW    = DW / 8;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // Owner of the read currently in flight in the memory.
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_I    = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;

  logic [3:0] starve_q, starve_d;
  logic [1:0] owner_q, owner_d;
  logic       starve_w;
  logic       i_gnt_w;
  logic       d_gnt_w;

  // I is forced through only when it is waiting and D has used up its run.
  assign starve_w = (starve_q == LIMIT) && i_req_i;
  assign d_gnt_w  = d_req_i && !starve_w;
  assign i_gnt_w  = i_req_i && !d_gnt_w;

  assign i_gnt_o   = i_gnt_w;
  assign d_gnt_o   = d_gnt_w;
  assign mem_req_o = i_gnt_w || d_gnt_w;

  // Memory command mux; idle cycles drive all-zero so the bus is quiet.
  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (d_gnt_w) begin
      mem_we_o    = d_we_i;
      mem_be_o    = d_be_i;
      mem_addr_o  = d_addr_i;
      mem_wdata_o = d_wdata_i;
    end else if (i_gnt_w) begin
      mem_be_o    = {BW{1'b1}};
      mem_addr_o  = i_addr_i;
    end
  end

  // Starvation counter next state: counts D wins over a waiting I, saturating.
  always_comb begin
    starve_d = starve_q;
    if (!i_req_i || i_gnt_w) begin
      starve_d = 4'd0;
    end else if (d_gnt_w && (starve_q != LIMIT)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // Owner next state: only reads produce a response, writes record none.
  always_comb begin
    owner_d = OWN_NONE;
    if (i_gnt_w) begin
      owner_d = OWN_I;
    end else if (d_gnt_w && !d_we_i) begin
      owner_d = OWN_D;
    end
  end

  // Arbitration state; reset drops any read still in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_q <= 4'd0;
      owner_q  <= OWN_NONE;
    end else begin
      starve_q <= starve_d;
      owner_q  <= owner_d;
    end
  end

  // Memory data is broadcast; only the owner's valid qualifies it.
  assign i_rvalid_o = (owner_q == OWN_I);
  assign d_rvalid_o = (owner_q == OWN_D);
  assign i_rdata_o  = mem_rdata_i;
  assign d_rdata_o  = mem_rdata_i;

`ifdef SIMPLE_MEM_ARB_PERF_EN
  logic [31:0] perf_conflict_q;
  logic [31:0] perf_i_stall_q;

  // Free-running wrapping event counters for contention and fetch stalls.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_conflict_q <= 32'd0;
      perf_i_stall_q  <= 32'd0;
    end else begin
      if (i_req_i && d_req_i) begin
        perf_conflict_q <= perf_conflict_q + 32'd1;
      end
      if (i_req_i && !i_gnt_w) begin
        perf_i_stall_q <= perf_i_stall_q + 32'd1;
      end
    end
  end

  assign perf_conflict_o = perf_conflict_q;
  assign perf_i_stall_o  = perf_i_stall_q;
`endif

endmodule
`default_nettype wire

// File: doc/simple_mem_arbiter.md
Name: simple_mem_arbiter

Overview:
- Shares one single-ported simple simulation memory between two requesters: instruction fetch (port I, read-only) and load/store unit (port D, read/write).
- Sits between the fetch unit / LSU and the memory model.
- Memory has fixed 1-cycle read latency; the arbiter routes each read response back to its owner.
- Data port has priority, with a starvation limit guaranteeing fetch progress.

Parameters:
- AW, 32, address width.
- DW, 32, data width; must be a multiple of 8.
- STARVE_LIMIT, 4, max consecutive D grants while I is requesting before I is forced a grant; range 1..15.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- i_req_i  in  1  fetch read request.
- i_addr_i  in  AW  fetch address.
- i_gnt_o  out  1  fetch request accepted this cycle.
- i_rvalid_o  out  1  fetch read data valid.
- i_rdata_o  out  DW  fetch read data.
- d_req_i  in  1  LSU request.
- d_we_i  in  1  1 = write, 0 = read.
- d_be_i  in  DW/8  byte enables for writes.
- d_addr_i  in  AW  LSU address.
- d_wdata_i  in  DW  LSU write data.
- d_gnt_o  out  1  LSU request accepted this cycle.
- d_rvalid_o  out  1  LSU read data valid (reads only).
- d_rdata_o  out  DW  LSU read data.
- mem_req_o  out  1  memory access strobe.
- mem_we_o  out  1  memory write.
- mem_be_o  out  DW/8  memory byte enables.
- mem_addr_o  out  AW  memory address.
- mem_wdata_o  out  DW  memory write data.
- mem_rdata_i  in  DW  memory read data, valid the cycle after a read strobe.

Behaviour:
Grant logic (combinational, same cycle as request):
- Grant goes to D if d_req_i, unless the starvation counter equals STARVE_LIMIT and i_req_i is high; then I is granted.
- Otherwise I is granted if i_req_i. At most one grant per cycle.
- mem_req_o = i_gnt_o | d_gnt_o. Address, we, be and wdata are muxed from the granted port.
- I grant forces mem_we_o = 0 and mem_be_o = all ones.
- Idle cycle: mem_req_o = 0, all other mem outputs = 0.

Starvation counter (4-bit):
- Increments on each cycle with d_gnt_o = 1 and i_req_i = 1.
- Clears on i_gnt_o, or on any cycle with i_req_i = 0.
- Saturates at STARVE_LIMIT.

Response routing:
- Owner register (2 bits: none / I / D) captures the owner of the granted read on each edge.
- D writes record "none".
- Next cycle: the owner's rvalid_o = 1, and both rdata_o outputs = mem_rdata_i.
- Exactly one rvalid per granted read, never one for a write.
- Back-to-back reads (one per cycle, alternating owners) are supported with no bubbles.

Reset values:
- Asserted: owner = none, counter = 0, i_rvalid_o = d_rvalid_o = 0.
- Grants and mem outputs depend only on inputs and counter, so both grants are 0 when no requests are present.

Boundary conditions:
- Simultaneous I and D requests with counter < STARVE_LIMIT: D granted, I stalls (gnt = 0). Requesters hold their request stable until granted.
- Reset asserted mid-operation: the outstanding read is dropped and no rvalid appears after reset deasserts.
- A requester may drop its request without a grant; no state changes.

Optional Feature:
- Macro: SIMPLE_MEM_ARB_PERF_EN.
- Enabled: adds outputs perf_conflict_o[31:0] (cycles with both requests) and perf_i_stall_o[31:0] (cycles with i_req_i & !i_gnt_o). Both are wrapping counters reset to 0.
- Disabled: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Fetch-only reads: i_req_i held for 3 cycles at 0x8000_0000, 0x8000_0004, 0x8000_0008 -> i_gnt_o = 1 each cycle; i_rvalid_o 1 cycle later with matching memory words; d_rvalid_o stays 0.
- D write: d_we_i = 1, be = 4'b0011, addr 0x100, wdata 0xDEADBEEF -> mem_we_o = 1, mem_be_o = 0011, no rvalid on either port. A following D read of 0x100 returns 0x????BEEF per memory model.
- Contention, STARVE_LIMIT = 4: I and D request continuously -> grant pattern D,D,D,D,I repeating; each I grant resets the counter.
- Interleaved reads: cycles alternate D read / I read with no gap -> rvalid alternates D/I on the following cycles, each carrying its own data.
- Reset mid-read: D read granted, rst_i pulsed in the next cycle -> d_rvalid_o = 0 during and after reset; counter = 0.
- With SIMPLE_MEM_ARB_PERF_EN: 10 cycles of dual requests -> perf_conflict_o = 10, and perf_i_stall_o = 8 with STARVE_LIMIT = 4.
